// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the sticky priority encoder.
// Optional round-robin priority is enabled by defining PRIO_ENC_RR_EN.
package prio_enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Bits needed to hold the values 0..n, which is every code plus the "none" value 0.
  function automatic int clog2_plus1(input int n);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((1 << i) < (n + 1)) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_select.sv
// Combinational search for the highest-priority pending request.
// With PRIO_ENC_RR_EN the search rotates below the last-granted index.
module prio_enc_select
  import prio_enc_pkg::*;
#(
  parameter int N  = 9,
  parameter int CW = clog2_plus1(N)
) (
  input  logic [N-1:0]  pending_i,
`ifdef PRIO_ENC_RR_EN
  input  logic [CW-1:0] rr_i,
`endif
  output logic [CW-1:0] sel_o,
  output logic          any_o
);

`ifdef PRIO_ENC_RR_EN
  logic [CW-1:0] start;
  logic [CW-1:0] hi;
  logic [CW-1:0] lo;
  logic          lo_any;

  // A downward search from start with wrap is the highest set bit at or below start,
  // or failing that the highest set bit overall.
  always_comb begin
    start  = (rr_i == '0) ? CW'(N - 1) : rr_i - CW'(1);
    hi     = '0;
    lo     = '0;
    lo_any = 1'b0;
    any_o  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_i[i]) begin
        any_o = 1'b1;
        hi    = CW'(i);
        if (CW'(i) <= start) begin
          lo_any = 1'b1;
          lo     = CW'(i);
        end
      end
    end
    sel_o = lo_any ? lo : hi;
  end
`else
  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_i[i]) begin
        any_o = 1'b1;
        sel_o = CW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/priority_encoder_sticky.sv
// Registered sticky priority encoder: captures active-low requests, grants one at a time
// with a valid/ack handshake. Define PRIO_ENC_RR_EN for round-robin priority.
module priority_encoder_sticky
  import prio_enc_pkg::*;
#(
  parameter int N  = 9,
  parameter int CW = clog2_plus1(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_n,
  input  logic          ack,
  output logic          valid,
  output logic [CW-1:0] code,
  output logic [N-1:0]  pending
);

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  clr;
  logic [CW-1:0] sel_q, sel_d;
  logic [CW-1:0] sel_new;
  logic          any_new;
  logic          take;
`ifdef PRIO_ENC_RR_EN
  logic [CW-1:0] rr_q;
`endif

  prio_enc_select #(.N(N), .CW(CW)) u_select (
    .pending_i (pending_q),
`ifdef PRIO_ENC_RR_EN
    .rr_i      (rr_q),
`endif
    .sel_o     (sel_new),
    .any_o     (any_new)
  );

  // Set wins: a line re-asserted in its own clear cycle stays pending.
  always_comb begin
    take = (state_q == GRANT) && ack;
    clr  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      clr[i] = take && (sel_q == CW'(i));
    end
    pending_d = (pending_q & ~clr) | ~req_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
    end
  end

`ifdef PRIO_ENC_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (take) begin
      rr_q <= sel_q;
    end
  end
`endif

  // sel is loaded only from IDLE, so late requests cannot disturb a held code.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (any_new) begin
          state_d = GRANT;
          sel_d   = sel_new;
        end
      end
      GRANT: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid   = (state_q == GRANT);
    code    = valid ? (sel_q + CW'(1)) : '0;
    pending = pending_q;
  end

endmodule

// File: doc/priority_encoder_sticky.md
# priority_encoder_sticky

Parametrised, registered successor to the 10-to-4 line priority encoder. It latches N active-low request lines into a sticky pending register and encodes the highest-priority pending request into an index-plus-one code. A valid/ack handshake holds each code stable until the consumer accepts it, then clears only the accepted request. It sits between raw request/interrupt lines and a sequential consumer such as a controller FSM.

## Interface
- N, default 9: number of request lines, 2..64.
- CW, default $clog2(N+1): code width; derived, do not override.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_n  input  N  active-low request lines; bit i low = request i.
- ack  input  1  consumer accepts the current code; ignored while valid is low.
- valid  output  1  code holds a granted request.
- code  output  CW  granted index+1; 0 when valid is low.
- pending  output  N  sticky pending register, active-high.

## Operation
- Sticky capture: every cycle, pending <= (pending & ~clr) | ~req_n.
  - clr is one-hot: the granted bit in an ack cycle, else 0.
  - A bit re-asserted in its own clear cycle stays set (set wins).
- FSM has two states.
  - IDLE: valid=0, code=0. If pending != 0, register sel and go to GRANT. Otherwise stay in IDLE.
  - GRANT: valid=1, code=sel+1, both held stable. On ack, clear pending[sel] and go to IDLE. Without ack, stay in GRANT.
- sel is the highest-priority set bit of pending as it is sampled in IDLE.
  - Default mode uses fixed priority: highest index wins, matching 74HC147 ordering (line N-1 → code N).
- Requests arriving while in GRANT only accumulate in pending. They never change code mid-grant, even at higher priority.
- All N lines high with pending empty: stays IDLE, code=0.
- code arithmetic is unsigned, CW bits. The maximum code is N, which always fits.

## Timing
- Reset, asynchronous: state=IDLE, pending=0, valid=0, code=0, rr pointer=0. Asserting reset mid-grant drops valid in the same instant. No ack is owed afterward.
- Capture latency: req_n low before edge k sets pending at edge k.
- Grant latency:
  - IDLE with pending set after edge k gives valid=1 after edge k+1.
  - From a request to valid is 2 edges.
- Ack at edge m (valid=1, ack=1 sampled):
  - The pending bit clears at m.
  - valid drops at m, and the state is IDLE for at least one cycle.
  - The next grant is valid after m+1 at the earliest.
  - Maximum throughput is one grant per 2 cycles.
- A 1-cycle pulse on req_n is never lost. It stays pending until granted and acked.
- An ack while valid=0 has no effect.

## Configuration
- PRIO_ENC_RR_EN defined: round-robin priority.
  - A pointer rr holds the last granted index and is updated on each ack.
  - The search starts at rr-1 and moves downward, wrapping from 0 to N-1. The last-granted line has the lowest priority.
  - At reset rr=0, so the first search starts at N-1, the same as fixed priority.
- PRIO_ENC_RR_EN undefined: fixed priority, highest index wins. No rr register is synthesised.

## Structure
- Shared package prio_enc_pkg holds:
  - the state enum (IDLE, GRANT);
  - a function clog2_plus1(n) for CW.
- One sub-module, prio_enc_select (combinational).
  - Inputs: pending, and rr when round-robin is enabled.
  - Output: sel plus an any flag.
  - It contains the fixed and rotating search.
- The top level holds the pending register, FSM, output registers and rr pointer.

## Test plan
- Reset then idle: rst_n low with req_n all 1 → valid=0, code=0, pending=0. All lines high for 10 cycles → remains idle.
- Single pulse: N=9, req_n[3] low for 1 cycle → pending[3]=1 next edge, then valid=1, code=4 one edge later. Ack → pending=0, valid=0.
- Fixed priority plus hold:
  - Stimulus: req 2 and 7 together; code=8 held for 5 cycles without ack. During the hold, raise req 8.
  - Required: code stays 8 until ack, then the next grants are 9, then 3.
- Set-wins on clear: ack for code=5 in the same cycle req_n[4] is low → pending[4] stays 1, and code=5 is regranted 2 edges later.
- Reset mid-grant: valid=1, code=6, rst_n pulsed low → valid=0, code=0, pending=0 immediately. No grant follows without new requests.
- PRIO_ENC_RR_EN: req 1, 5 and 8 held low continuously, ack every grant → codes cycle 9, 6, 2, 9, 6, 2. Without the macro → code 9 repeats every grant.
